// File: rtl/alu.sv
// alu: 4-bit registered ALU, 16 opcodes, registered zero/negative flags.
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] op,
  input  logic [3:0] rx,
  input  logic [3:0] ry,
  output logic [3:0] out,
  output logic       z,
  output logic       n
);
  logic [3:0] out_q, out_d, diff, flag_src;
  logic       z_q, n_q;
  logic [1:0] sh;
  logic [7:0] rol_w, ror_w;
  assign sh    = ry[1:0];
  assign diff  = rx - ry;
  assign rol_w = {rx, rx} << sh;
  assign ror_w = {rx, rx} >> sh;
  always_comb begin
    case (op)
      4'h0:    out_d = rx + ry;
      4'h1:    out_d = diff;
      4'h2:    out_d = rx & ry;
      4'h3:    out_d = rx | ry;
      4'h4:    out_d = rx ^ ry;
      4'h5:    out_d = ~rx;
      4'h6:    out_d = rx << sh;
      4'h7:    out_d = rx >> sh;
      4'h8:    out_d = $signed(rx) >>> sh;
      4'h9:    out_d = rol_w[7:4];
      4'ha:    out_d = ror_w[3:0];
      4'hb:    out_d = rx + 4'd1;
      4'hc:    out_d = rx - 4'd1;
      4'hd:    out_d = 4'd0 - rx;
      4'he:    out_d = ry;
      default: out_d = out_q;
    endcase
  end
  // CMP keeps out but still reports flags of rx-ry
  assign flag_src = (op == 4'hf) ? diff : out_d;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= 4'd0;
      z_q   <= 1'b1;
      n_q   <= 1'b0;
    end else begin
      out_q <= out_d;
      z_q   <= flag_src == 4'd0;
      n_q   <= flag_src[3];
    end
  end
  assign out = out_q;
  assign z   = z_q;
  assign n   = n_q;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed plus randomized checks of alu against an arithmetic reference model.
module tb_alu;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] op = 4'd0, rx = 4'd0, ry = 4'd0;
  logic [3:0] out;
  logic       z, n;
  int checks = 0, errors = 0;
  logic [3:0] m_out = 4'd0;
  logic       m_z = 1'b1, m_n = 1'b0;

  alu dut (.clk(clk), .rst(rst), .op(op), .rx(rx), .ry(ry), .out(out), .z(z), .n(n));

  always #5 clk = ~clk;

  function automatic int ref_res(input int o, input int a, input int b, input int prev);
    int r, s;
    s = b % 4;
    r = a;
    case (o)
      0: r = (a + b) % 16;
      1: r = (a - b + 16) % 16;
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 15 - a;
      6: r = (a * (1 << s)) % 16;
      7: r = a / (1 << s);
      8: repeat (s) r = r / 2 + (r >= 8 ? 8 : 0);
      9: repeat (s) r = (r * 2) % 16 + r / 8;
      10: repeat (s) r = r / 2 + (r % 2) * 8;
      11: r = (a + 1) % 16;
      12: r = (a + 15) % 16;
      13: r = (16 - a) % 16;
      14: r = b;
      default: r = prev;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eo, input logic ez, input logic en);
    chk({tag, ".out"}, out, eo);
    chk({tag, ".z"}, {3'b0, z}, {3'b0, ez});
    chk({tag, ".n"}, {3'b0, n}, {3'b0, en});
  endtask

  task automatic apply(input logic [3:0] o, input logic [3:0] a, input logic [3:0] b);
    int r, f;
    @(negedge clk);
    op = o; rx = a; ry = b;
    @(posedge clk);
    #1;
    r = ref_res(int'(o), int'(a), int'(b), int'(m_out));
    f = (o == 4'hf) ? (int'(a) - int'(b) + 16) % 16 : r;
    m_out = 4'(r);
    m_z = (f == 0);
    m_n = (f >= 8);
    chk_all($sformatf("model op%0d", o), m_out, m_z, m_n);
  endtask

  task automatic res(input string tag, input logic [3:0] eo);
    chk_all(tag, eo, eo == 4'd0, eo[3]);
  endtask

  task automatic model_reset();
    m_out = 4'd0; m_z = 1'b1; m_n = 1'b0;
  endtask

  logic [3:0] sweep [15];
  initial begin
    sweep = '{4'h6, 4'h4, 4'h1, 4'h5, 4'h4, 4'hA, 4'hA, 4'h2,
              4'h2, 4'hA, 4'hA, 4'h6, 4'h4, 4'hB, 4'h1};
    #3;
    op = 4'hd; rx = 4'h9; ry = 4'h7;
    rst = 1'b1;
    #1;
    chk_all("async_reset", 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_all("reset_held", 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_all("after_release", 4'h0, 1'b1, 1'b0);
    model_reset();

    for (int i = 0; i < 15; i++) begin
      apply(4'(i), 4'h5, 4'h1);
      res($sformatf("sweep op%0d", i), sweep[i]);
    end
    apply(4'hf, 4'h5, 4'h1);
    chk_all("sweep cmp", 4'h1, 1'b0, 1'b0);

    apply(4'h0, 4'hf, 4'h1); chk_all("add_wrap", 4'h0, 1'b1, 1'b0);
    apply(4'h1, 4'h5, 4'h5); chk_all("sub_zero", 4'h0, 1'b1, 1'b0);
    apply(4'h1, 4'h0, 4'h1); chk_all("sub_wrap", 4'hf, 1'b0, 1'b1);
    apply(4'hb, 4'hf, 4'h0); res("inc_wrap", 4'h0);
    apply(4'hc, 4'h0, 4'h0); res("dec_wrap", 4'hf);
    apply(4'hd, 4'h8, 4'h0); res("neg_min", 4'h8);

    apply(4'h8, 4'h8, 4'h2); res("asr2", 4'he);
    apply(4'h7, 4'h8, 4'h2); res("shr2", 4'h2);
    apply(4'h9, 4'h8, 4'h3); res("rol3", 4'h4);
    apply(4'h6, 4'h8, 4'h4); res("shl_sh0", 4'h8);
    apply(4'ha, 4'h1, 4'h1); res("ror1", 4'h8);

    apply(4'he, 4'h0, 4'h7); res("mov", 4'h7);
    apply(4'hf, 4'h3, 4'h3); chk_all("cmp_eq", 4'h7, 1'b1, 1'b0);
    apply(4'hf, 4'h1, 4'h2); chk_all("cmp_lt", 4'h7, 1'b0, 1'b1);

    for (int i = 0; i < 4; i++) apply(4'(i), 4'h5, 4'h1);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk_all("mid_reset", 4'h0, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk_all("mid_reset_held", 4'h0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 4; i < 15; i++) begin
      apply(4'(i), 4'h5, 4'h1);
      res($sformatf("resume op%0d", i), sweep[i]);
    end

    repeat (300) apply(4'($urandom), 4'($urandom), 4'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
